// File: rtl/board_scan_reader_pkg.sv
// Shared constants, types and colour selection for the board scan-out path.
package board_scan_reader_pkg;

  localparam int BOARD_SIZE = 256;
  localparam int WORD_W     = 32;
  localparam int CELL_SHIFT = 1;
  localparam int READ_LAT   = 2;
  localparam int H_ACTIVE   = 1024;
  localparam int H_TOTAL    = 1344;
  localparam int V_TOTAL    = 806;

  localparam int WORDS        = BOARD_SIZE / WORD_W;
  localparam int IDX_W        = $clog2(WORDS);
  localparam int LOG_BOARD    = $clog2(BOARD_SIZE);
  localparam int CELL_IDX_W   = $clog2(WORD_W);
  localparam int DRAIN_W      = $clog2(READ_LAT + 1);
  localparam int LOG_MAX_ADDR = 1 + $clog2(BOARD_SIZE * BOARD_SIZE / WORD_W);

  typedef logic [LOG_MAX_ADDR-1:0] board_addr_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [11:0] COL_BLANK      = 12'h000;
  localparam logic [11:0] COL_BG         = 12'h333;
  localparam logic [11:0] COL_CUR_ALIVE  = 12'hF80;
  localparam logic [11:0] COL_CUR_DEAD   = 12'hF00;
  localparam logic [11:0] COL_ALIVE      = 12'hFFF;
  localparam logic [11:0] COL_DEAD       = 12'h000;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b0, vsync: 1'b0, blank: 1'b1};

  function automatic logic [11:0] pick_colour(logic blank, logic inboard,
                                              logic cursor, logic alive);
    if (blank)    return COL_BLANK;
    if (!inboard) return COL_BG;
    if (cursor)   return alive ? COL_CUR_ALIVE : COL_CUR_DEAD;
    return alive ? COL_ALIVE : COL_DEAD;
  endfunction

endpackage

// File: rtl/board_scan_reader_line_fetch_fsm.sv
// Fetches one board row per horizontal blank and streams the returning words
// to the back line buffer in the parent.
module line_fetch_fsm
  import board_scan_reader_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              bank_sel_in,
  output board_addr_t       addr_r_out,
  input  logic [WORD_W-1:0] data_r_in,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [WORD_W-1:0] wr_data,
  output logic              fill_start,
  output logic              fill_skip
);

  logic [1:0]                    state;
  logic [IDX_W-1:0]              word_cnt;
  logic [LOG_BOARD-1:0]          row_r;
  logic                          bank_r;
  logic [DRAIN_W-1:0]            drain_cnt;
  logic [READ_LAT:0]             vld_pipe;
  logic [READ_LAT:0][IDX_W-1:0]  idx_pipe;

  logic [10:0] next_line, row_full;
  logic        trigger, row_ok, frame_start;

  always_comb begin
    next_line   = (vcount_in == 10'(V_TOTAL - 1)) ? 11'd0 : {1'b0, vcount_in} + 11'd1;
    row_full    = next_line >> CELL_SHIFT;
    row_ok      = row_full < 11'(BOARD_SIZE);
    trigger     = hcount_in == 11'(H_ACTIVE);
    frame_start = trigger && (next_line == 11'd0);
  end

  assign fill_start = (state == ST_IDLE) && trigger && row_ok;
  assign fill_skip  = (state == ST_IDLE) && trigger && !row_ok;

  // Stage 0 travels with the address; stage READ_LAT lines up with data_r_in.
  assign wr_en   = vld_pipe[READ_LAT];
  assign wr_idx  = idx_pipe[READ_LAT];
  assign wr_data = data_r_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      word_cnt   <= '0;
      row_r      <= '0;
      bank_r     <= 1'b0;
      drain_cnt  <= '0;
      addr_r_out <= '0;
      vld_pipe   <= '0;
      idx_pipe   <= '0;
    end else begin
      vld_pipe[READ_LAT:1] <= vld_pipe[READ_LAT-1:0];
      idx_pipe[READ_LAT:1] <= idx_pipe[READ_LAT-1:0];
      vld_pipe[0]          <= 1'b0;
      // Bank is frozen for the whole frame, even if a fetch is still running.
      if (frame_start) bank_r <= bank_sel_in;
      case (state)
        ST_IDLE: begin
          if (fill_start) begin
            state    <= ST_ISSUE;
            row_r    <= row_full[LOG_BOARD-1:0];
            word_cnt <= '0;
          end
        end
        ST_ISSUE: begin
          addr_r_out  <= {bank_r, row_r, word_cnt};
          vld_pipe[0] <= 1'b1;
          idx_pipe[0] <= word_cnt;
          word_cnt    <= word_cnt + 1'b1;
          if (word_cnt == IDX_W'(WORDS - 1)) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_W'(READ_LAT - 1)) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/board_scan_reader.sv
// Double-buffered line scan-out of the board with cursor overlay; fixed
// two-cycle latency from timing inputs to pixel/sync outputs.
module board_scan_reader
  import board_scan_reader_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [10:0]          hcount_in,
  input  logic [9:0]           vcount_in,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 blank_in,
  input  logic                 bank_sel_in,
  input  logic [LOG_BOARD-1:0] cursor_x_in,
  input  logic [LOG_BOARD-1:0] cursor_y_in,
  output board_addr_t          addr_r_out,
  input  logic [WORD_W-1:0]    data_r_in,
  output logic [11:0]          pixel_out,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic                 blank_out
);

  if (WORDS + READ_LAT > H_TOTAL - H_ACTIVE) begin : g_fetch_too_long
    $error("board row fetch does not fit inside horizontal blank");
  end

  logic                  wr_en, fill_start, fill_skip;
  logic [IDX_W-1:0]      wr_idx;
  logic [WORD_W-1:0]     wr_data;

  line_fetch_fsm u_fetch (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .hcount_in   (hcount_in),
    .vcount_in   (vcount_in),
    .bank_sel_in (bank_sel_in),
    .addr_r_out  (addr_r_out),
    .data_r_in   (data_r_in),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .fill_start  (fill_start),
    .fill_skip   (fill_skip)
  );

  logic [1:0][BOARD_SIZE-1:0] line_buf;
  logic [1:0]                 buf_valid;
  logic                       front_sel, back_sel;
  logic [LOG_BOARD-1:0]       wr_base;

  assign back_sel = ~front_sel;
  assign wr_base  = {wr_idx, {CELL_IDX_W{1'b0}}};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      line_buf  <= '0;
      buf_valid <= 2'b11;
      front_sel <= 1'b0;
    end else begin
      if (fill_start) buf_valid[back_sel] <= 1'b1;
      if (fill_skip)  buf_valid[back_sel] <= 1'b0;
      if (wr_en)      line_buf[back_sel][wr_base +: WORD_W] <= wr_data;
      if (hcount_in == 11'(H_TOTAL - 1)) front_sel <= back_sel;
    end
  end

  logic [10:0]    x_cell;
  logic [9:0]     y_cell;
  sync_t [1:0]    sync_pipe;
  logic           s1_alive, s1_inboard, s1_cursor;

  assign x_cell = hcount_in >> CELL_SHIFT;
  assign y_cell = vcount_in >> CELL_SHIFT;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_pipe  <= {2{SYNC_IDLE}};
      s1_alive   <= 1'b0;
      s1_inboard <= 1'b0;
      s1_cursor  <= 1'b0;
      pixel_out  <= '0;
    end else begin
      sync_pipe[0] <= '{hsync: hsync_in, vsync: vsync_in, blank: blank_in};
      sync_pipe[1] <= sync_pipe[0];
      s1_alive     <= line_buf[front_sel][x_cell[LOG_BOARD-1:0]];
      s1_inboard   <= (x_cell < 11'(BOARD_SIZE)) && buf_valid[front_sel];
      s1_cursor    <= (x_cell == 11'(cursor_x_in)) && (y_cell == 10'(cursor_y_in));
      pixel_out    <= pick_colour(sync_pipe[0].blank, s1_inboard, s1_cursor, s1_alive);
    end
  end

  assign hsync_out = sync_pipe[1].hsync;
  assign vsync_out = sync_pipe[1].vsync;
  assign blank_out = sync_pipe[1].blank;

endmodule
